// File: rtl/design_45_pkg.sv
// Shared types and defaults for the design_45 initiator-side driver.
package design_45_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } drv_state_e;

  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/design_45_drv_tmr.sv
// WAIT-cycle counter: clear on issue, count while enabled, saturate at TIMEOUT-1.
// exp_o is a pure decode of the count register, so it carries no input path.
module design_45_drv_tmr
  import design_45_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic exp_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign exp_o = (cnt_q == LAST);

endmodule

// File: rtl/design_45_drv.sv
// Initiator driver: accepts an operand pair, pulses start to the core, waits for
// valid (or times out) and returns the captured result on a ready/valid port.
module design_45_drv
  import design_45_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic         start,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  input  logic [W-1:0] y,
  input  logic         valid,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_y,
  output logic         rsp_err,
  output logic         stray
);

  drv_state_e   state_q;
  logic         cmd_ready_q;
  logic         start_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         rsp_valid_q;
  logic [W-1:0] rsp_y_q;
  logic         rsp_err_q;
  logic         stray_q;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_exp;

  // The ISSUE cycle zeroes the counter so WAIT starts at wcnt=0.
  assign tmr_clr = (state_q == ST_ISSUE);
  assign tmr_en  = (state_q == ST_WAIT);

  design_45_drv_tmr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .exp_o(tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      start_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_err_q   <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (valid && ((state_q == ST_IDLE) || (state_q == ST_RESP))) begin
        stray_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_ready_q && cmd_valid) begin
            a_q         <= cmd_a;
            b_q         <= cmd_b;
            start_q     <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_ISSUE;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (valid) begin
            rsp_y_q     <= y;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A result on the expiry cycle still counts as a success.
          if (valid) begin
            rsp_y_q     <= y;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (tmr_exp) begin
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign start     = start_q;
  assign a         = a_q;
  assign b         = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;
  assign stray     = stray_q;

endmodule

// File: doc/design_45_drv.md
# design_45_drv

Initiator-side driver for the design_45 operand/result interface. It accepts one operand pair per command over a ready/valid port and issues a single-cycle `start` with operands held stable. It waits for the core's `valid`, captures `y`, and returns the result (or a timeout error) over a ready/valid response port. It sits between a command source (testbench sequencer or firmware-facing register block) and a design_45 instance.

## Interface
- `W`, 8: operand and result width.
- `TIMEOUT`, 16: maximum WAIT cycles before error; ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when both are high.
- `cmd_a` in W: operand A.
- `cmd_b` in W: operand B.
- `start` out 1: one-cycle request pulse to core.
- `a` out W: operand A to core, registered.
- `b` out W: operand B to core, registered.
- `y` in W: core result.
- `valid` in 1: core result qualifier.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when both are high.
- `rsp_y` out W: captured result.
- `rsp_err` out 1: response is a timeout (`rsp_y`=0).
- `stray` out 1: sticky; `valid` seen while not in ISSUE/WAIT. Cleared only by `rst`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `cmd_a`/`cmd_b` into `a`/`b`, then go to ISSUE.
- ISSUE
  - `start`=1 for exactly this cycle.
  - If `valid`=1 this cycle, capture `y` and go to RESP. Otherwise go to WAIT with `wcnt`=0.
- WAIT
  - If `valid`=1, capture `y`, set err=0, and go to RESP.
  - Else if `wcnt`==TIMEOUT-1, set `rsp_y`=0, err=1, and go to RESP.
  - Else `wcnt`++.
- RESP
  - `rsp_valid`=1; `rsp_y`/`rsp_err` are stable until handshake.
  - On `rsp_ready`, go to IDLE.
- `a`/`b` are held from the accept cycle until the next accept; they never change while busy.
- `valid` arriving in the same cycle as timeout expiry wins: the result is captured and err=0.
- `valid` in IDLE or RESP is ignored for data and sets `stray`.
- `wcnt` width is $clog2(TIMEOUT). It saturates and never wraps.
- `rst` mid-transaction:
  - state goes to IDLE.
  - all outputs clear on the next edge.
  - the pending command and response are discarded.
- Reset values: `cmd_ready`=0 during the reset cycle, then 1 in IDLE. `start`=0, `a`=`b`=0, `rsp_valid`=0, `rsp_y`=0, `rsp_err`=0, `stray`=0.

## Timing
- Accept at edge T. `start`=1 during cycle T+1 (ISSUE).
- Core latency L cycles after `start` (`valid` in cycle T+1+L):
  - L=0 gives `rsp_valid` at T+2.
  - L≥1 gives `rsp_valid` at T+2+L.
- Timeout gives `rsp_valid` at T+2+TIMEOUT.
- Minimum back-to-back throughput: one command per 3 cycles (IDLE→ISSUE→RESP with L=0 and `rsp_ready` held high).
- `cmd_ready` is never asserted in the same cycle as `rsp_valid`.
- All outputs are registered; no input-to-output combinational path.

## Structure
- Shared package `design_45_pkg` holds:
  - the FSM state enum (IDLE/ISSUE/WAIT/RESP).
  - the default `W` and `TIMEOUT` localparams.
- One natural sub-module: `design_45_drv_tmr`, the WAIT-cycle counter with clear/enable/expire. Everything else stays flat.

## Test plan
- Reset, then `cmd_a`=8'h12, `cmd_b`=8'h34, core `valid` 2 cycles after `start`, `y`=8'h46:
  - `start` pulses once.
  - `rsp_valid` at accept+4 with `rsp_y`=8'h46 and `rsp_err`=0.
  - `a`/`b` stay at 12/34 throughout.
- `valid` in the ISSUE cycle (L=0), `y`=8'hFF, `rsp_ready` held high: `rsp_valid` at accept+2 with `rsp_y`=8'hFF.
- Three back-to-back commands, `rsp_ready`=1, L=0: three responses, one every 3 cycles, with no dropped or duplicated `start`.
- Core never raises `valid`, TIMEOUT=16: `rsp_valid` at accept+18 with `rsp_err`=1 and `rsp_y`=0. Then a following normal command completes cleanly.
- `valid`=1 at exactly `wcnt`=15: result captured with `rsp_err`=0. Separately, hold `rsp_ready`=0 for 5 cycles: `rsp_y` stays stable and `cmd_ready` stays 0.
- Pulse `rst` during WAIT: next cycle state is IDLE with all outputs 0. Inject `valid` while IDLE: `stray`=1 and it stays 1 until `rst`.
